dma_mem_responder: RTL and testbench
====================================

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, cycles inserted between request capture and response (0..15).
REQ-002 Parameter DEPTH_LOG2, default 6, log2 of storage depth in 16-bit words.
REQ-003 Parameter BASE_ADDR, default 16'h0000, byte base address of the decoded window.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 slv_addr  input  16  byte address from the DMA port (dma_addr_pN); bit 0 ignored.
REQ-007 slv_en  input  1  request valid; held by the initiator until slv_ready is seen high.
REQ-008 slv_wen  input  2  byte-lane write enables; 2'b00 = read, [0] = low byte, [1] = high byte.
REQ-009 slv_din  input  16  write data.
REQ-010 slv_ready  output  1  one-cycle transfer-complete strobe.
REQ-011 slv_dout  output  16  read data; valid only while slv_ready is high.
REQ-012 slv_resp  output  1  response code valid with slv_ready: 0 = OKAY, 1 = ERROR.

Function
REQ-013 FSM states are IDLE, WAIT and RESP.
REQ-014 IDLE with slv_en=1 shall capture addr/wen/din, load the wait counter with WAIT_STATES, and enter WAIT, or enter RESP directly when WAIT_STATES=0.
REQ-015 WAIT shall decrement the counter each cycle and enter RESP when the counter reaches 0, giving slv_ready in cycle T+1+WAIT_STATES after capture cycle T.
REQ-016 RESP shall drive slv_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 A slv_en sampled during RESP is not accepted; the next capture occurs no earlier than the following IDLE cycle, so the minimum transfer period is WAIT_STATES+2 cycles.
REQ-018 slv_en deasserted during WAIT shall abort the transfer: return to IDLE, no memory write, no slv_ready.
REQ-019 In-range means BASE_ADDR <= addr < BASE_ADDR + 2*2^DEPTH_LOG2, with word index (addr-BASE_ADDR)[DEPTH_LOG2:1].
REQ-020 An in-range write shall update only the enabled byte lanes, committed on the RESP cycle edge, with slv_resp=0.
REQ-021 An in-range read shall drive the stored word on slv_dout during RESP, with slv_resp=0.
REQ-022 An out-of-range access shall write nothing and return slv_resp=1, with slv_dout=16'h0000.
REQ-023 Outside RESP, slv_ready=0, slv_resp=0 and slv_dout=16'h0000.
REQ-024 Address and data shall be used as captured; changes on the inputs after capture have no effect.

Reset
REQ-025 reset_n low shall force IDLE, counter=0, slv_ready=0, slv_resp=0, slv_dout=16'h0000 and all storage words to 16'h0000, immediately and regardless of clk.
REQ-026 Reset asserted mid-transfer shall discard the transfer; no partial write and no slv_ready after release.
REQ-027 The first capture is possible on the first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package dma_bus_pkg shall hold the RESP_OKAY/RESP_ERROR constants, the WEN_READ encoding and the FSM state encoding.
REQ-029 Storage shall be the sub-module dma_resp_mem: a 2^DEPTH_LOG2 x 16 register file with byte-lane write, asynchronous read and asynchronous clear.
REQ-030 Two instances shall be able to serve dma_addr_p1 and dma_addr_p2 independently, with no shared state.

Verification
REQ-031 Write addr=16'h0004, wen=2'b11, din=16'hA55A, then read 16'h0004 -> slv_ready 3 cycles after each capture (WAIT_STATES=2); read returns 16'hA55A with resp=0.
REQ-032 Word 16'h0010 holds 16'h1234; write wen=2'b10, din=16'hABCD -> subsequent read returns 16'hAB34.
REQ-033 Read 16'h0080 (DEPTH_LOG2=6, BASE_ADDR=0) -> slv_resp=1, slv_dout=16'h0000; no word is changed.
REQ-034 Drop slv_en one cycle into WAIT on a write of 16'hFFFF -> no slv_ready, and the target word is unchanged.
REQ-035 Assert reset_n=0 during WAIT after a prior write of 16'h5555 -> slv_ready stays 0, and reads after release return 16'h0000.
REQ-036 With WAIT_STATES=0, hold slv_en high for back-to-back reads -> slv_ready pulses every 2nd cycle.

Source files
------------

// File: rtl/dma_bus_pkg.sv
// dma_bus_pkg: shared response codes, read encoding and responder FSM states
package dma_bus_pkg;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
  localparam logic [1:0] WEN_READ = 2'b00;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dma_resp_mem.sv
// dma_resp_mem: 2^DEPTH_LOG2 x 16 register file; clk/reset_n (async clear), we+be byte-lane write at idx, async rdata
module dma_resp_mem #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);
  logic [15:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
    else if (we) begin
      if (be[0]) mem[idx][7:0] <= wdata[7:0];
      if (be[1]) mem[idx][15:8] <= wdata[15:8];
    end
  assign rdata = mem[idx];
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: DMA slave memory with WAIT_STATES latency; in slv_addr/en/wen/din, out slv_ready strobe, slv_dout, slv_resp (1=out of window)
module dma_mem_responder
  import dma_bus_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] slv_addr,
  input  logic        slv_en,
  input  logic [1:0]  slv_wen,
  input  logic [15:0] slv_din,
  output logic        slv_ready,
  output logic [15:0] slv_dout,
  output logic        slv_resp
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [16:0] SPAN = 17'd2 << DEPTH_LOG2;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic cap;
  logic [15:0] addr_q, din_q, off, rdata;
  logic [1:0] wen_q;
  logic in_range, resp_st;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      wen_q <= '0;
      din_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (cap) begin
        addr_q <= slv_addr;
        wen_q <= slv_wen;
        din_q <= slv_din;
      end
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    cap = 1'b0;
    case (state)
      ST_IDLE:
        if (slv_en) begin
          cap = 1'b1;
          cnt_d = WS;
          state_d = WS == 4'd0 ? ST_RESP : ST_WAIT;
        end
      ST_WAIT: begin
        cnt_d = slv_en ? cnt - 4'd1 : 4'd0;
        state_d = !slv_en ? ST_IDLE : cnt == 4'd1 ? ST_RESP : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign off = addr_q - BASE_ADDR;
  assign in_range = addr_q >= BASE_ADDR && {1'b0, off} < SPAN;
  assign resp_st = state == ST_RESP;
  dma_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .reset_n(reset_n),
    .we(resp_st && in_range && wen_q != WEN_READ),
    .be(wen_q),
    .idx(off[DEPTH_LOG2:1]),
    .wdata(din_q),
    .rdata(rdata)
  );
  assign slv_ready = resp_st;
  assign slv_resp = resp_st && !in_range ? RESP_ERROR : RESP_OKAY;
  assign slv_dout = resp_st && in_range && wen_q == WEN_READ ? rdata : 16'h0000;
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: directed vectors plus multi-cycle abort, reset and zero-wait back-to-back sequences
module tb_dma_mem_responder;
  logic clk = 1'b0, reset_n;
  logic [15:0] slv_addr, slv_din, slv_dout;
  logic [1:0] slv_wen;
  logic slv_en, slv_ready, slv_resp;
  logic [15:0] addr0, din0, dout0;
  logic [1:0] wen0;
  logic en0, ready0, resp0;
  int ncmp = 0, nerr = 0;
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  wen;
    logic [15:0] din;
    logic        resp;
    logic [15:0] dout;
  } vec_t;
  vec_t v[15];
  always #5 clk = ~clk;
  dma_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .slv_addr(slv_addr), .slv_en(slv_en), .slv_wen(slv_wen),
    .slv_din(slv_din), .slv_ready(slv_ready), .slv_dout(slv_dout), .slv_resp(slv_resp)
  );
  dma_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .slv_addr(addr0), .slv_en(en0), .slv_wen(wen0),
    .slv_din(din0), .slv_ready(ready0), .slv_dout(dout0), .slv_resp(resp0)
  );
  task automatic check(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h want %h", n, i, act, exp);
    end
  endtask
  // Starts and ends 1 time unit after a rising edge with the DUT idle; inputs are scrambled after capture.
  task automatic xfer(input logic [15:0] a, input logic [1:0] w, input logic [15:0] d,
                      output logic rdy, output logic [15:0] dout, output logic resp, output int lat);
    slv_addr = a;
    slv_wen = w;
    slv_din = d;
    slv_en = 1'b1;
    lat = 0;
    rdy = 1'b0;
    dout = '0;
    resp = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        slv_addr = ~a;
        slv_wen = ~w;
        slv_din = ~d;
      end
      rdy = slv_ready;
      dout = slv_dout;
      resp = slv_resp;
    end
    slv_en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string n, input logic [15:0] a, input logic [1:0] w, input logic [15:0] d,
                     input logic er, input logic [15:0] ed);
    logic rdy, resp;
    logic [15:0] dout;
    int lat;
    xfer(a, w, d, rdy, dout, resp, lat);
    check({n, "_lat"}, 0, lat, 3);
    check({n, "_resp"}, 0, resp, er);
    if (w == 2'b00) check({n, "_dout"}, 0, dout, ed);
  endtask
  initial begin
    logic rdy, resp, seen;
    logic [15:0] dout;
    int lat;
    v[0]  = '{16'h0004, 2'b11, 16'hA55A, 1'b0, 16'h0000};
    v[1]  = '{16'h0004, 2'b00, 16'h0000, 1'b0, 16'hA55A};
    v[2]  = '{16'h0010, 2'b11, 16'h1234, 1'b0, 16'h0000};
    v[3]  = '{16'h0010, 2'b10, 16'hABCD, 1'b0, 16'h0000};
    v[4]  = '{16'h0010, 2'b00, 16'h0000, 1'b0, 16'hAB34};
    v[5]  = '{16'h0011, 2'b01, 16'h00EE, 1'b0, 16'h0000};
    v[6]  = '{16'h0011, 2'b00, 16'h0000, 1'b0, 16'hABEE};
    v[7]  = '{16'h0080, 2'b00, 16'h0000, 1'b1, 16'h0000};
    v[8]  = '{16'h0080, 2'b11, 16'hFFFF, 1'b1, 16'h0000};
    v[9]  = '{16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000};
    v[10] = '{16'h007E, 2'b11, 16'hBEEF, 1'b0, 16'h0000};
    v[11] = '{16'h007E, 2'b00, 16'h0000, 1'b0, 16'hBEEF};
    v[12] = '{16'h0002, 2'b01, 16'h1234, 1'b0, 16'h0000};
    v[13] = '{16'h0002, 2'b00, 16'h0000, 1'b0, 16'h0034};
    v[14] = '{16'h0004, 2'b00, 16'h0000, 1'b0, 16'hA55A};
    reset_n = 1'b0;
    {slv_addr, slv_din, slv_wen, slv_en} = '0;
    {addr0, din0, wen0, en0} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 0, slv_ready, 1'b0);
    check("rst_resp", 0, slv_resp, 1'b0);
    check("rst_dout", 0, slv_dout, 16'h0000);
    check("rst_ready0", 0, ready0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      xfer(v[i].addr, v[i].wen, v[i].din, rdy, dout, resp, lat);
      check("vec_lat", i, lat, 3);
      check("vec_resp", i, resp, v[i].resp);
      if (v[i].wen == 2'b00) check("vec_dout", i, dout, v[i].dout);
    end
    slv_addr = 16'h0004;
    slv_wen = 2'b11;
    slv_din = 16'hFFFF;
    slv_en = 1'b1;
    @(posedge clk);
    #1;
    slv_en = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= slv_ready;
    end
    check("abort_ready", 0, seen, 1'b0);
    run("abort_read", 16'h0004, 2'b00, 16'h0000, 1'b0, 16'hA55A);
    run("w5555", 16'h0020, 2'b11, 16'h5555, 1'b0, 16'h0000);
    slv_addr = 16'h0020;
    slv_wen = 2'b00;
    slv_en = 1'b1;
    lat = 0;
    while (!slv_ready && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("resp_cyc_lat", 0, lat, 3);
    check("resp_cyc_dout", 0, slv_dout, 16'h5555);
    reset_n = 1'b0;
    #1;
    check("async_ready", 0, slv_ready, 1'b0);
    check("async_dout", 0, slv_dout, 16'h0000);
    slv_en = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run("rw5555", 16'h0020, 2'b11, 16'h5555, 1'b0, 16'h0000);
    run("rr5555", 16'h0020, 2'b00, 16'h0000, 1'b0, 16'h5555);
    slv_addr = 16'h0020;
    slv_wen = 2'b11;
    slv_din = 16'hAAAA;
    slv_en = 1'b1;
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    check("wait_rst_ready", 0, slv_ready, 1'b0);
    slv_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen |= slv_ready;
    end
    check("post_rst_ready", 0, seen, 1'b0);
    run("post_rst_rd20", 16'h0020, 2'b00, 16'h0000, 1'b0, 16'h0000);
    run("post_rst_rd04", 16'h0004, 2'b00, 16'h0000, 1'b0, 16'h0000);
    addr0 = 16'h0006;
    wen0 = 2'b11;
    din0 = 16'h1111;
    en0 = 1'b1;
    @(posedge clk);
    #1;
    check("ws0_wr_ready", 0, ready0, 1'b1);
    check("ws0_wr_resp", 0, resp0, 1'b0);
    en0 = 1'b0;
    @(posedge clk);
    #1;
    wen0 = 2'b00;
    en0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("ws0_ready", k, ready0, k % 2);
      if (k % 2 == 1) check("ws0_dout", k, dout0, 16'h1111);
    end
    en0 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
